cipher_sequencer: RTL and testbench

CIPHER_SEQUENCER -- requirements
Module: cipher_sequencer

---
 rtl/cipher_sequencer_if.sv | 26 ++
 rtl/cipher_sequencer.sv | 96 +++++++++
 tb/tb_cipher_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_sequencer_if.sv
// Job-control and register-file port bundle for cipher_sequencer.
// The master modport is the sequencer's side; the slave modport is the job issuer and register file.
interface cipher_sequencer_if;
    logic        start;
    logic [9:0]  src_base;
    logic [9:0]  dst_base;
    logic [9:0]  length;
    logic [15:0] key_access;
    logic [31:0] rf_memory_out;
    logic        rf_read_enable;
    logic [9:0]  rf_address;
    logic [31:0] rf_write_data;
    logic        busy;
    logic        done;
    logic [9:0]  words_done;

    modport master (
        input  start, src_base, dst_base, length, key_access, rf_memory_out,
        output rf_read_enable, rf_address, rf_write_data, busy, done, words_done
    );

    modport slave (
        output start, src_base, dst_base, length, key_access, rf_memory_out,
        input  rf_read_enable, rf_address, rf_write_data, busy, done, words_done
    );
endinterface

// File: rtl/cipher_sequencer.sv
// Copies length words from src_base to dst_base through the register file,
// XOR-ing each word with the doubled key and its index; two cycles per word.
module cipher_sequencer (
    input  logic               clk,
    input  logic               rst,
    cipher_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e      state_q, state_d;
    logic [9:0]  src_q, src_d;
    logic [9:0]  dst_q, dst_d;
    logic [9:0]  len_q, len_d;
    logic [15:0] key_q, key_d;
    logic [9:0]  idx_q, idx_d;
    logic [9:0]  words_done_q, words_done_d;
    logic [9:0]  idx_inc;

    assign idx_inc = idx_q + 10'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            key_q        <= '0;
            idx_q        <= '0;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            key_q        <= key_d;
            idx_q        <= idx_d;
            words_done_q <= words_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        key_d        = key_q;
        idx_d        = idx_q;
        words_done_d = words_done_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    src_d        = bus.src_base;
                    dst_d        = bus.dst_base;
                    len_d        = bus.length;
                    key_d        = bus.key_access;
                    idx_d        = '0;
                    words_done_d = '0;
                    state_d      = (bus.length == 10'd0) ? DONE : READ;
                end
            end
            READ:  state_d = WRITE;
            WRITE: begin
                idx_d        = idx_inc;
                words_done_d = words_done_q + 10'd1;
                state_d      = (idx_inc == len_q) ? DONE : READ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read-enable defaults high so only the WRITE state can ever modify the register file.
    always_comb begin
        bus.rf_read_enable = 1'b1;
        bus.rf_address     = '0;
        bus.rf_write_data  = '0;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        case (state_q)
            READ: begin
                bus.rf_address = src_q + idx_q;
                bus.busy       = 1'b1;
            end
            WRITE: begin
                bus.rf_read_enable = 1'b0;
                bus.rf_address     = dst_q + idx_q;
                bus.rf_write_data  = bus.rf_memory_out ^ {key_q, key_q} ^ {22'b0, idx_q};
                bus.busy           = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.words_done = words_done_q;
endmodule

// File: tb/tb_cipher_sequencer.sv
// Scoreboard bench for cipher_sequencer: a job-level reference model queues expected
// reads, writes and done pulses; a forked monitor checks them against the DUT.
module tb_cipher_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cipher_sequencer_if sq ();

    cipher_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (sq)
    );

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic [31:0] data;
    } acc_t;

    acc_t rd_q[$];
    acc_t wr_q[$];
    acc_t dn_q[$];

    logic [31:0] mem    [1024];
    logic [31:0] refmem [1024];
    logic        poke_en;
    logic [9:0]  poke_addr;
    logic [31:0] poke_data;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          done_count = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: registered read data, write when read_enable is low.
    always @(posedge clk) begin
        if (poke_en)
            mem[poke_addr] <= poke_data;
        else if (!sq.rf_read_enable)
            mem[sq.rf_address] <= sq.rf_write_data;
        if (sq.rf_read_enable)
            sq.rf_memory_out <= mem[sq.rf_address];
    end

    task automatic check(input bit ok, input string name, input string got, input string want);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %s, want %s", name, got, want);
        end
    endtask

    task automatic monitor();
        acc_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!sq.busy)
                    check(sq.rf_read_enable === 1'b1 && sq.rf_address === 10'd0 && sq.rf_write_data === 32'd0,
                          "idle_outputs",
                          $sformatf("cyc=%0d re=%b addr=%h wd=%h", cyc, sq.rf_read_enable, sq.rf_address, sq.rf_write_data),
                          "re=1 addr=000 wd=00000000");
                if (sq.busy && sq.rf_read_enable) begin
                    if (rd_q.size() == 0)
                        check(1'b0, "unexpected_read", $sformatf("cyc=%0d addr=%h", cyc, sq.rf_address), "no read");
                    else begin
                        e = rd_q.pop_front();
                        check(e.cyc == cyc && sq.rf_address === e.addr, "read",
                              $sformatf("cyc=%0d addr=%h", cyc, sq.rf_address),
                              $sformatf("cyc=%0d addr=%h", e.cyc, e.addr));
                    end
                end
                if (!sq.rf_read_enable) begin
                    if (wr_q.size() == 0)
                        check(1'b0, "unexpected_write", $sformatf("cyc=%0d addr=%h", cyc, sq.rf_address), "no write");
                    else begin
                        e = wr_q.pop_front();
                        check(e.cyc == cyc && sq.rf_address === e.addr && sq.rf_write_data === e.data && sq.busy === 1'b1,
                              "write",
                              $sformatf("cyc=%0d addr=%h data=%h busy=%b", cyc, sq.rf_address, sq.rf_write_data, sq.busy),
                              $sformatf("cyc=%0d addr=%h data=%h busy=1", e.cyc, e.addr, e.data));
                    end
                end
                if (sq.done) begin
                    done_count++;
                    if (dn_q.size() == 0)
                        check(1'b0, "unexpected_done", $sformatf("cyc=%0d", cyc), "no done");
                    else begin
                        e = dn_q.pop_front();
                        check(e.cyc == cyc && sq.words_done === e.addr && sq.busy === 1'b0, "done",
                              $sformatf("cyc=%0d words_done=%0d busy=%b", cyc, sq.words_done, sq.busy),
                              $sformatf("cyc=%0d words_done=%0d busy=0", e.cyc, e.addr));
                    end
                end
            end
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        refmem[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        int first = -1;
        for (int a = 0; a < 1024; a++)
            if (mem[a] !== refmem[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        check(bad == 0, name, $sformatf("%0d differing words (first at %0d)", bad, first), "0 differing words");
    endtask

    // Reference model: word i of the job lands at dst+i as src-word ^ {key,key} ^ i,
    // applied in ascending order so overlapping ranges see earlier results.
    task automatic expect_job(input int t0, input logic [9:0] s, input logic [9:0] d,
                              input int nwords, input logic [15:0] k);
        logic [9:0]  ii;
        logic [9:0]  ra;
        logic [9:0]  wa;
        logic [31:0] val;
        for (int i = 0; i < nwords; i++) begin
            ii  = i[9:0];
            ra  = s + ii;
            wa  = d + ii;
            val = refmem[ra] ^ {k, k} ^ {22'b0, ii};
            refmem[wa] = val;
            rd_q.push_back('{cyc: t0 + 1 + 2 * i, addr: ra, data: 32'd0});
            wr_q.push_back('{cyc: t0 + 2 + 2 * i, addr: wa, data: val});
        end
    endtask

    task automatic run_job(input logic [9:0] s, input logic [9:0] d, input logic [9:0] l,
                           input logic [15:0] k, input bit poke_start);
        int t0;
        int base_done;
        int n;
        n = int'(l);
        @(negedge clk);
        sq.src_base   = s;
        sq.dst_base   = d;
        sq.length     = l;
        sq.key_access = k;
        sq.start      = 1'b1;
        t0 = cyc;
        expect_job(t0, s, d, n, k);
        dn_q.push_back('{cyc: t0 + 1 + 2 * n, addr: l, data: 32'd0});
        base_done = done_count;
        @(negedge clk);
        sq.start = 1'b0;
        if (poke_start && n >= 2) begin
            @(negedge clk);
            @(negedge clk);
            sq.start      = 1'b1;
            sq.src_base   = 10'($urandom);
            sq.dst_base   = 10'($urandom);
            sq.length     = 10'($urandom);
            sq.key_access = 16'($urandom);
            @(negedge clk);
            sq.start = 1'b0;
        end
        for (int w = 0; w < 2 * n + 20 && done_count == base_done; w++)
            @(negedge clk);
        check(done_count != base_done, "done_timeout", "no done pulse", "done pulse");
        @(negedge clk);
        @(negedge clk);
        check(sq.words_done === l && sq.busy === 1'b0, "words_done_hold",
              $sformatf("words_done=%0d busy=%b", sq.words_done, sq.busy),
              $sformatf("words_done=%0d busy=0", l));
        check_mem("mem_after_job");
    endtask

    initial begin
        fork
            monitor();
        join_none
        rst           = 1'b1;
        sq.start      = 1'b0;
        sq.src_base   = '0;
        sq.dst_base   = '0;
        sq.length     = '0;
        sq.key_access = '0;
        poke_en       = 1'b0;
        poke_addr     = '0;
        poke_data     = '0;
        for (int a = 0; a < 1024; a++)
            poke(a[9:0], $urandom);

        check(sq.rf_read_enable === 1'b1 && sq.rf_address === 10'd0 && sq.rf_write_data === 32'd0 &&
              sq.busy === 1'b0 && sq.done === 1'b0 && sq.words_done === 10'd0, "reset_values",
              $sformatf("re=%b addr=%h wd=%h busy=%b done=%b wdone=%0d", sq.rf_read_enable, sq.rf_address,
                        sq.rf_write_data, sq.busy, sq.done, sq.words_done),
              "re=1 addr=000 wd=00000000 busy=0 done=0 wdone=0");
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Basic job with known data.
        poke(10'h010, 32'hDEADBEEF);
        run_job(10'h010, 10'h200, 10'd3, 16'h0032, 1'b0);
        check(mem[10'h200] === 32'hDE9FBEDD, "basic_word0", $sformatf("%h", mem[10'h200]), "de9fbedd");

        // Empty job.
        run_job(10'h123, 10'h321, 10'd0, 16'hBEEF, 1'b0);

        // Address wrap, in place.
        run_job(10'h3FF, 10'h3FF, 10'd2, 16'hA5C3, 1'b0);

        // In-place identity with zero key.
        poke(10'h005, 32'h12345678);
        run_job(10'h005, 10'h005, 10'd1, 16'h0000, 1'b0);
        check(mem[10'h005] === 32'h12345678, "identity", $sformatf("%h", mem[10'h005]), "12345678");

        // Start pulse while busy must be ignored.
        run_job(10'h040, 10'h060, 10'd6, 16'h1357, 1'b1);

        // Start coincident with reset is ignored.
        @(negedge clk);
        rst       = 1'b1;
        sq.start  = 1'b1;
        sq.length = 10'd3;
        @(negedge clk);
        rst      = 1'b0;
        sq.start = 1'b0;
        repeat (4) @(negedge clk);
        check(sq.busy === 1'b0 && sq.words_done === 10'd0, "start_during_reset",
              $sformatf("busy=%b words_done=%0d", sq.busy, sq.words_done), "busy=0 words_done=0");

        // Reset mid-job: reset edge at the start of cycle 4 of a length-5 job.
        begin
            int t0;
            @(negedge clk);
            sq.src_base   = 10'h100;
            sq.dst_base   = 10'h180;
            sq.length     = 10'd5;
            sq.key_access = 16'h4242;
            sq.start      = 1'b1;
            t0 = cyc;
            expect_job(t0, 10'h100, 10'h180, 1, 16'h4242);
            rd_q.push_back('{cyc: t0 + 3, addr: 10'h101, data: 32'd0});
            @(negedge clk);
            sq.start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check(sq.busy === 1'b0 && sq.rf_read_enable === 1'b1 && sq.words_done === 10'd0, "reset_abort",
                  $sformatf("busy=%b re=%b words_done=%0d", sq.busy, sq.rf_read_enable, sq.words_done),
                  "busy=0 re=1 words_done=0");
            repeat (12) @(negedge clk);
            check_mem("mem_after_abort");
        end

        // Randomized jobs, some with overlapping ranges and stray start pulses.
        for (int j = 0; j < 30; j++) begin
            logic [9:0] s;
            logic [9:0] d;
            logic [9:0] l;
            s = 10'($urandom);
            d = ($urandom_range(0, 2) == 0) ? s + 10'($urandom_range(0, 3)) : 10'($urandom);
            l = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(20, 60)) : 10'($urandom_range(0, 12));
            run_job(s, d, l, 16'($urandom), 1'($urandom_range(0, 1)));
        end

        check(rd_q.size() == 0 && wr_q.size() == 0 && dn_q.size() == 0, "queues_drained",
              $sformatf("rd=%0d wr=%0d dn=%0d", rd_q.size(), wr_q.size(), dn_q.size()), "rd=0 wr=0 dn=0");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
